relu_layer_sequencer: RTL and testbench



---
 rtl/relu_layer_sequencer_pkg.sv | 22 ++
 rtl/relu_layer_sequencer_if.sv | 27 ++
 rtl/relu.sv | 17 +
 rtl/relu_out_fifo.sv | 41 ++++
 rtl/relu_layer_sequencer.sv | 127 ++++++++++++
 tb/tb_relu_layer_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/relu_layer_sequencer_pkg.sv
// Shared types and sizing for the ReLU layer sequencer.
package relu_layer_sequencer_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned Q       = 15;
  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned AW      = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } seq_state_e;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [AW-1:0] index;
    logic          last;
  } fifo_entry_t;

endpackage

// File: rtl/relu_layer_sequencer_if.sv
// Downstream activation stream: valid/ready with per-beat index and last flag.
interface relu_layer_sequencer_if;
  import relu_layer_sequencer_pkg::*;

  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_index;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/relu.sv
// Leaky-style activation: negative inputs are shifted down by 3 with the sign cleared.
module relu #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] x,
  input  logic             en,
  output logic [Width-1:0] y
);

  always_comb begin
    y = x;
    if (en && x[Width-1]) begin
      y = {1'b0, x[Width-2:0] >> 3};
    end
  end

endmodule

// File: rtl/relu_out_fifo.sv
// Two-entry synchronous FIFO with occupancy count; push and pop may coincide when full.
module relu_out_fifo
  import relu_layer_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic [1:0]  count
);

  fifo_entry_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/relu_layer_sequencer.sv
// Reads one layer's pre-activations from SRAM, applies ReLU and streams them out.
// Credit-limited issue keeps at most two values between the SRAM and the consumer.
module relu_layer_sequencer
  import relu_layer_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          act_en,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  relu_layer_sequencer_if.master out
);

  localparam logic [AW:0] LenOne = 1;

  seq_state_e    state_q, state_d;
  logic [AW:0]   len_q;
  logic [AW:0]   len_m1;
  logic [AW:0]   rd_cnt_q;
  logic          act_en_q;
  logic          inflight_q;
  logic [AW-1:0] ret_index_q;

  logic [1:0]    fifo_count;
  logic [1:0]    occ_after_pop;
  logic [2:0]    credit_used;
  logic          pop;
  logic          push;
  logic [N-1:0]  act_data;
  fifo_entry_t   push_entry;
  fifo_entry_t   head;

  assign len_m1        = len_q - LenOne;
  assign out.out_valid = (fifo_count != 2'd0);
  assign pop           = out.out_valid & out.out_ready;

  // Credits: entries left after this cycle's pop plus the read returning now.
  assign occ_after_pop = fifo_count - {1'b0, pop};
  assign credit_used   = {1'b0, occ_after_pop} + {2'b00, inflight_q};
  assign rd_en         = (state_q == StRun) && (credit_used < 3'd2) && (rd_cnt_q < len_q);
  assign rd_addr       = rd_cnt_q[AW-1:0];

  relu #(
    .Width(N)
  ) u_relu (
    .x (rd_data),
    .en(act_en_q),
    .y (act_data)
  );

  assign push       = inflight_q;
  assign push_entry = '{data: act_data, index: ret_index_q,
                        last: ({1'b0, ret_index_q} == len_m1)};

  relu_out_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign out.out_data  = head.data;
  assign out.out_index = head.index;
  assign out.out_last  = head.last;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (rd_en && (rd_cnt_q == len_m1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (pop && head.last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      act_en_q    <= 1'b0;
      inflight_q  <= 1'b0;
      ret_index_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if ((state_q == StIdle) && start) begin
        len_q    <= len;
        act_en_q <= act_en;
        rd_cnt_q <= '0;
      end
      if (rd_en) begin
        rd_cnt_q    <= rd_cnt_q + LenOne;
        ret_index_q <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Directed bench for relu_layer_sequencer with an SRAM model and a stream monitor.
module tb_relu_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic        act_en;
  logic        busy, done, rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;

  relu_layer_sequencer_if out_if ();

  relu_layer_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .len    (len),
    .act_en (act_en),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out    (out_if)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [64];
  always @(posedge clk) if (rd_en) rd_data <= sram[rd_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor (sampled mid-cycle)
  logic [31:0] bq_data [$];
  int          bq_index [$];
  bit          bq_last [$];
  int rd_count, done_count, done_cyc, first_valid_cyc, credit_viol, outstanding;
  bit busy_seen, valid_seen;

  always @(negedge clk) begin
    int pop;
    if (!reset) begin
      pop = (out_if.out_valid && out_if.out_ready) ? 1 : 0;
      if (out_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_if.out_valid) valid_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) begin done_count++; done_cyc = cyc; end
      if (rd_en) begin
        rd_count++;
        if (outstanding - pop >= 2) credit_viol++;
      end
      if (pop == 1) begin
        bq_data.push_back(out_if.out_data);
        bq_index.push_back(int'(out_if.out_index));
        bq_last.push_back(out_if.out_last);
      end
      outstanding = outstanding + (rd_en ? 1 : 0) - pop;
    end
  end

  function automatic logic [31:0] exp_relu(input logic [31:0] x, input bit a);
    if (a && x[31]) return {1'b0, x[30:0] >> 3};
    return x;
  endfunction

  task automatic clear_log();
    bq_data.delete(); bq_index.delete(); bq_last.delete();
    rd_count = 0; done_count = 0; done_cyc = -1; first_valid_cyc = -1;
    credit_viol = 0; outstanding = 0; busy_seen = 1'b0; valid_seen = 1'b0;
  endtask

  task automatic start_pass(input int l, input bit a);
    start = 1'b1; len = 7'(l); act_en = a; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (rnd) out_if.out_ready = ($urandom_range(0, 9) < 3);
      if (done_count > 0) begin ok = 1'b1; break; end
    end
    out_if.out_ready = 1'b1;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, rd_en, out_if.out_valid, out_if.out_last} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {busy, done, rd_en, out_if.out_valid, out_if.out_last});
    end
    vectors++;
    if (out_if.out_data !== 32'h0 || out_if.out_index !== 6'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%0d want 0/0", out_if.out_data, out_if.out_index);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_len4(input bit a);
    logic [31:0] raw [4];
    logic [31:0] act [4];
    raw = '{32'h0001_0000, 32'hFFFF_FFF8, 32'h0000_0000, 32'h8000_0008};
    act = '{32'h0001_0000, 32'h0FFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    for (int i = 0; i < 4; i++) sram[i] = raw[i];
    clear_log();
    start_pass(4, a);
    wait_done(30, 1'b0, "len4");
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done_cyc - start_cyc != 7) begin
      miscompares++;
      $display("FAIL len4_latency act=%0d: got %0d want 7", a, done_cyc - start_cyc);
    end
    vectors++;
    if (first_valid_cyc - start_cyc != 3) begin
      miscompares++;
      $display("FAIL len4_first_valid act=%0d: got %0d want 3", a, first_valid_cyc - start_cyc);
    end
    vectors++;
    if (bq_data.size() != 4 || rd_count != 4 || done_count != 1) begin
      miscompares++;
      $display("FAIL len4_counts act=%0d: beats %0d reads %0d dones %0d want 4/4/1",
               a, bq_data.size(), rd_count, done_count);
    end
    for (int i = 0; i < 4 && i < bq_data.size(); i++) begin
      vectors++;
      if (bq_data[i] !== (a ? act[i] : raw[i]) || bq_index[i] != i || bq_last[i] != (i == 3)) begin
        miscompares++;
        $display("FAIL len4_beat%0d act=%0d: got %h/%0d/%0d want %h/%0d/%0d", i, a,
                 bq_data[i], bq_index[i], bq_last[i], a ? act[i] : raw[i], i, i == 3);
      end
    end
  endtask

  task automatic test_len_max();
    int errs = 0;
    for (int i = 0; i < 64; i++)
      sram[i] = (i % 2 == 1) ? (32'h8000_0000 | (32'(i) << 8) | 32'h0F) : 32'(i) * 32'h0101_0001;
    clear_log();
    start_pass(64, 1'b1);
    wait_done(2000, 1'b1, "lenmax");
    vectors++;
    if (bq_data.size() != 64 || rd_count != 64) begin
      miscompares++;
      $display("FAIL lenmax_counts: beats %0d reads %0d want 64/64", bq_data.size(), rd_count);
    end
    for (int i = 0; i < 64 && i < bq_data.size(); i++)
      if (bq_data[i] !== exp_relu(sram[i], 1'b1) || bq_index[i] != i || bq_last[i] != (i == 63))
        errs++;
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL lenmax_stream: %0d bad beats want 0", errs);
    end
    vectors++;
    if (credit_viol != 0) begin
      miscompares++;
      $display("FAIL lenmax_credit: %0d reads over credit want 0", credit_viol);
    end
  endtask

  task automatic test_len0();
    clear_log();
    start_pass(0, 1'b1);
    wait_done(10, 1'b0, "len0");
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done_cyc - start_cyc != 1 || done_count != 1) begin
      miscompares++;
      $display("FAIL len0_done: at +%0d count %0d want +1 count 1", done_cyc - start_cyc,
               done_count);
    end
    vectors++;
    if (rd_count != 0 || valid_seen || busy_seen) begin
      miscompares++;
      $display("FAIL len0_quiet: reads %0d valid %0d busy %0d want 0/0/0", rd_count,
               valid_seen, busy_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_data;
    int hold_idx, unstable = 0, errs = 0;
    for (int i = 0; i < 16; i++) sram[i] = 32'hC000_0000 ^ (32'(i) * 32'h0123_4567);
    clear_log();
    start_pass(16, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bq_data.size() >= 4) break;
    end
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        hold_data = out_if.out_data;
        hold_idx  = int'(out_if.out_index);
      end else if (!out_if.out_valid || out_if.out_data !== hold_data ||
                   int'(out_if.out_index) != hold_idx) begin
        unstable++;
      end
    end
    vectors++;
    if (unstable != 0 || hold_idx != bq_data.size()) begin
      miscompares++;
      $display("FAIL stall_hold: unstable %0d head %0d want 0 head %0d", unstable, hold_idx,
               bq_data.size());
    end
    vectors++;
    if (rd_count - bq_data.size() > 2) begin
      miscompares++;
      $display("FAIL stall_reads: %0d reads beyond last pop want <=2",
               rd_count - bq_data.size());
    end
    out_if.out_ready = 1'b1;
    wait_done(100, 1'b0, "stall");
    for (int i = 0; i < 16 && i < bq_data.size(); i++)
      if (bq_data[i] !== exp_relu(sram[i], 1'b1) || bq_index[i] != i) errs++;
    vectors++;
    if (bq_data.size() != 16 || errs != 0) begin
      miscompares++;
      $display("FAIL stall_resume: beats %0d bad %0d want 16/0", bq_data.size(), errs);
    end
  endtask

  task automatic test_reset_abort();
    bit hit = 1'b0;
    for (int i = 0; i < 16; i++) sram[i] = 32'h0000_1000 + 32'(i);
    clear_log();
    start_pass(16, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 6'd5) begin hit = 1'b1; break; end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL abort_reach: read of index 5 not seen");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, rd_en, out_if.out_valid, out_if.out_last} !== 5'b0 ||
        out_if.out_data !== 32'h0 || out_if.out_index !== 6'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: ctrl %b data %h idx %0d want 0",
               {busy, done, rd_en, out_if.out_valid, out_if.out_last}, out_if.out_data,
               out_if.out_index);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (done_count != 0) begin
      miscompares++;
      $display("FAIL abort_done: %0d done pulses want 0", done_count);
    end
    clear_log();
    start_pass(2, 1'b1);
    wait_done(30, 1'b0, "abort_new");
    vectors++;
    if (bq_data.size() != 2 || rd_count != 2) begin
      miscompares++;
      $display("FAIL abort_new_counts: beats %0d reads %0d want 2/2", bq_data.size(), rd_count);
    end
    for (int i = 0; i < 2 && i < bq_data.size(); i++) begin
      vectors++;
      if (bq_data[i] !== sram[i] || bq_index[i] != i || bq_last[i] != (i == 1)) begin
        miscompares++;
        $display("FAIL abort_new_beat%0d: got %h/%0d/%0d want %h/%0d/%0d", i, bq_data[i],
                 bq_index[i], bq_last[i], sram[i], i, i == 1);
      end
    end
  endtask

  initial begin
    start = 1'b0; len = '0; act_en = 1'b0; out_if.out_ready = 1'b1;
    clear_log();
    test_reset();
    test_len4(1'b1);
    test_len4(1'b0);
    test_len_max();
    test_len0();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
